// File: rtl/systolic_feeder.sv
// systolic_feeder: reads one A and one B operand vector per K step from the operand buffers,
// streams them into the systolic array, then waits out the array drain window before done.
module systolic_feeder #(
  parameter int N = 4,
  parameter int DATA_W = 8,
  parameter int K_MAX = 64,
  parameter int ADDR_W = 8,
  parameter int DRAIN_CYCLES = 2*N+3,
  localparam int KW = $clog2(K_MAX+1),
  localparam int DW = $clog2(DRAIN_CYCLES+1)
)(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [KW-1:0]              k_len_i,
  input  logic [ADDR_W-1:0]          a_base_i,
  input  logic [ADDR_W-1:0]          b_base_i,
  input  logic                       stall_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       a_rd_en_o,
  output logic                       b_rd_en_o,
  output logic [ADDR_W-1:0]          a_rd_addr_o,
  output logic [ADDR_W-1:0]          b_rd_addr_o,
  input  logic [N-1:0][DATA_W-1:0]   a_rd_data_i,
  input  logic [N-1:0][DATA_W-1:0]   b_rd_data_i,
  output logic                       arr_en_o,
  output logic                       arr_last_o,
  output logic [N-1:0][DATA_W-1:0]   arr_a_o,
  output logic [N-1:0][DATA_W-1:0]   arr_b_o
);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
  state_t state, state_nxt;
  logic [KW-1:0] k_len_q, issued;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DW-1:0] drain_cnt;
  logic arr_en_q, arr_last_q, rd_en, last_issue;
  // The drain window is counted from the arr_last beat, so the counter holds during that beat.
  always_comb begin
    rd_en = (state == FEED) && !stall_i;
    last_issue = rd_en && (KW'(issued + 1'b1) == k_len_q);
    done_o = (state == DRAIN) && (drain_cnt == DW'(1)) && !arr_last_q;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start_i ? ((k_len_i != '0) ? FEED : DRAIN) : IDLE;
      FEED:    state_nxt = last_issue ? DRAIN : FEED;
      DRAIN:   state_nxt = done_o ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      k_len_q <= '0;
      issued <= '0;
      a_addr <= '0;
      b_addr <= '0;
      drain_cnt <= '0;
      arr_en_q <= 1'b0;
      arr_last_q <= 1'b0;
    end else begin
      state <= state_nxt;
      arr_en_q <= rd_en;
      arr_last_q <= last_issue;
      if (state == IDLE && start_i) begin
        k_len_q <= k_len_i;
        a_addr <= a_base_i;
        b_addr <= b_base_i;
        issued <= '0;
        drain_cnt <= DW'(1);
      end
      if (rd_en) begin
        a_addr <= a_addr + 1'b1;
        b_addr <= b_addr + 1'b1;
        issued <= issued + 1'b1;
      end
      if (last_issue) drain_cnt <= DW'(DRAIN_CYCLES);
      else if (state == DRAIN && !arr_last_q) drain_cnt <= drain_cnt - 1'b1;
    end
  end
  assign busy_o = (state != IDLE);
  assign a_rd_en_o = rd_en;
  assign b_rd_en_o = rd_en;
  assign a_rd_addr_o = a_addr;
  assign b_rd_addr_o = b_addr;
  assign arr_en_o = arr_en_q;
  assign arr_last_o = arr_last_q;
  assign arr_a_o = arr_en_q ? a_rd_data_i : '0;
  assign arr_b_o = arr_en_q ? b_rd_data_i : '0;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: table-driven and randomized tiles checked cycle by cycle against a schedule
// derived from the stall pattern, with synchronous-read operand buffers modelled as arrays.
module tb_systolic_feeder;
  localparam int N = 4, DW = 8, K_MAX = 64, AW = 8, D = 2*N+3, KW = $clog2(K_MAX+1);
  logic clk = 0, rst = 1, start = 0, stall = 0;
  logic [KW-1:0] k_len = '0;
  logic [AW-1:0] a_base = '0, b_base = '0;
  logic busy, done, a_rd_en, b_rd_en, arr_en, arr_last;
  logic [AW-1:0] a_rd_addr, b_rd_addr;
  logic [N-1:0][DW-1:0] a_data, b_data, arr_a, arr_b;
  logic [N-1:0][DW-1:0] a_mem [256];
  logic [N-1:0][DW-1:0] b_mem [256];
  int n_chk = 0, n_fail = 0;
  typedef struct {int k; int ab; int bb; int st_lo; int st_hi; bit hold; int last_c; int done_c;} vec_t;
  vec_t tbl [6];
  systolic_feeder #(.N(N), .DATA_W(DW), .K_MAX(K_MAX), .ADDR_W(AW), .DRAIN_CYCLES(D)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .k_len_i(k_len), .a_base_i(a_base), .b_base_i(b_base),
    .stall_i(stall), .busy_o(busy), .done_o(done), .a_rd_en_o(a_rd_en), .b_rd_en_o(b_rd_en),
    .a_rd_addr_o(a_rd_addr), .b_rd_addr_o(b_rd_addr), .a_rd_data_i(a_data), .b_rd_data_i(b_data),
    .arr_en_o(arr_en), .arr_last_o(arr_last), .arr_a_o(arr_a), .arr_b_o(arr_b));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (a_rd_en) a_data <= a_mem[a_rd_addr];
    if (b_rd_en) b_data <= b_mem[b_rd_addr];
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Cycle 0 presents start in IDLE; the k reads land on the first k unstalled cycles from cycle 1.
  task automatic run_tile(input int k, input int ab, input int bb, input logic [63:0] smask,
                          input bit hold, output int o_last, output int o_done);
    int iss [256];
    int n, cy, last_e, done_e, prev;
    for (int i = 0; i < 256; i++) iss[i] = -1;
    n = 0; cy = 1; last_e = -1;
    while (n < k) begin
      if (!(cy < 64 && smask[cy])) begin
        iss[cy] = n;
        if (n == k-1) last_e = cy + 1;
        n++;
      end
      cy++;
    end
    done_e = (k == 0) ? 1 : last_e + D;
    o_last = -1; o_done = -1;
    for (int c = 0; c <= done_e + 1; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (hold && c <= done_e);
      k_len = KW'(k); a_base = AW'(ab); b_base = AW'(bb);
      stall = (c < 64) && smask[c];
      @(negedge clk);
      prev = (c > 0) ? iss[c-1] : -1;
      chk("busy", busy, c >= 1 && c <= done_e);
      chk("a_rd_en", a_rd_en, iss[c] >= 0);
      chk("b_rd_en", b_rd_en, iss[c] >= 0);
      if (iss[c] >= 0) begin
        chk("a_rd_addr", a_rd_addr, (ab + iss[c]) % 256);
        chk("b_rd_addr", b_rd_addr, (bb + iss[c]) % 256);
      end
      chk("arr_en", arr_en, prev >= 0);
      chk("arr_last", arr_last, prev >= 0 && prev == k-1);
      chk("arr_a", arr_a, (prev >= 0) ? a_mem[(ab + prev) % 256] : '0);
      chk("arr_b", arr_b, (prev >= 0) ? b_mem[(bb + prev) % 256] : '0);
      chk("done", done, c == done_e);
      if (arr_last) o_last = c;
      if (done) o_done = c;
    end
  endtask
  initial begin
    int ol, od;
    logic [63:0] m;
    for (int i = 0; i < 256; i++) begin
      a_mem[i] = $urandom;
      b_mem[i] = $urandom;
    end
    tbl[0] = '{4, 'h10, 'h20, 0, -1, 0, 5, 16};
    tbl[1] = '{6, 'h40, 'h80, 3, 4, 0, 9, 20};
    tbl[2] = '{1, 'h05, 'h06, 0, -1, 0, 2, 13};
    tbl[3] = '{0, 'h33, 'h44, 0, -1, 0, -1, 1};
    tbl[4] = '{2, 'h70, 'h90, 0, -1, 1, 3, 14};
    tbl[5] = '{4, 'hFE, 'h30, 0, -1, 0, 5, 16};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", a_rd_en, 0);
    chk("rst_arr_en", arr_en, 0);
    chk("rst_addr", {a_rd_addr, b_rd_addr}, 0);
    @(posedge clk); #1 rst = 0;
    for (int r = 0; r < 6; r++) begin
      m = '0;
      for (int c = tbl[r].st_lo; c <= tbl[r].st_hi; c++) m[c] = 1'b1;
      run_tile(tbl[r].k, tbl[r].ab, tbl[r].bb, m, tbl[r].hold, ol, od);
      chk("last_cycle", ol, tbl[r].last_c);
      chk("done_cycle", od, tbl[r].done_c);
    end
    // Reset in the middle of a tile, right after the second K step is read.
    @(posedge clk); #1 start = 1; k_len = 4; a_base = 'h10; b_base = 'h20; stall = 0;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_rd_en", a_rd_en, 1);
    chk("pre_rst_arr_en", arr_en, 1);
    #1 rst = 1; #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_rd_en", {a_rd_en, b_rd_en}, 0);
    chk("arst_addr", {a_rd_addr, b_rd_addr}, 0);
    chk("arst_arr_en", {arr_en, arr_last}, 0);
    chk("arst_arr_data", {arr_a, arr_b}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    run_tile(4, 'h10, 'h20, '0, 0, ol, od);
    chk("rerun_last", ol, 5);
    chk("rerun_done", od, 16);
    for (int t = 0; t < 30; t++) begin
      m = {$urandom, $urandom} & {$urandom, $urandom};
      run_tile($urandom_range(0, 20), $urandom_range(0, 255), $urandom_range(0, 255), m,
               1'($urandom_range(0, 1)), ol, od);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
